// File: rtl/match_controller_if.sv
// Control/status bundle between the game logic and the match controller.
// The master drives the game events; the slave (the controller) reports match status.
interface match_controller_if;
  logic       tick;
  logic       start;
  logic       pause_req;
  logic       goal_one;
  logic       goal_two;
  logic [2:0] state;
  logic       play_en;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] score_one;
  logic [3:0] score_two;
  logic [1:0] winner;
  logic       goal_flash;
  logic       beep_req;

  modport master (
    output tick, start, pause_req, goal_one, goal_two,
    input  state, play_en, ball_reset, serve_dir, score_one, score_two, winner,
           goal_flash, beep_req
  );

  modport slave (
    input  tick, start, pause_req, goal_one, goal_two,
    output state, play_en, ball_reset, serve_dir, score_one, score_two, winner,
           goal_flash, beep_req
  );
endinterface

// File: rtl/match_controller.sv
// Pong match sequencer: serve countdown, scoring, goal freeze, pause/resume and game-over.
// Every output is driven straight from a flop.
module match_controller #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned GOAL_HOLD   = 30
) (
  input logic               clk,
  input logic               reset,
  match_controller_if.slave bus
);

  localparam logic [3:0] WinScore   = 4'(WIN_SCORE);
  localparam logic [7:0] ServeDelay = 8'(SERVE_DELAY);
  localparam logic [7:0] GoalHold   = 8'(GOAL_HOLD);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StServe  = 3'd1,
    StPlay   = 3'd2,
    StGoal   = 3'd3,
    StPaused = 3'd4,
    StOver   = 3'd5
  } state_e;

  state_e     state_q, state_d;
  state_e     saved_q, saved_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_one_q, score_one_d;
  logic [3:0] score_two_q, score_two_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic       play_en_q, play_en_d;
  logic       goal_flash_q, goal_flash_d;
  logic       ball_reset_q, ball_reset_d;
  logic       beep_q, beep_d;

  // Single-cycle events raised by the next-state logic, registered as pulses.
  logic       ball_reset_evt;
  logic       beep_evt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      saved_q      <= StServe;
      cnt_q        <= 8'd0;
      score_one_q  <= 4'd0;
      score_two_q  <= 4'd0;
      winner_q     <= 2'd0;
      serve_dir_q  <= 1'b0;
      play_en_q    <= 1'b0;
      goal_flash_q <= 1'b0;
      ball_reset_q <= 1'b0;
      beep_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      cnt_q        <= cnt_d;
      score_one_q  <= score_one_d;
      score_two_q  <= score_two_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      play_en_q    <= play_en_d;
      goal_flash_q <= goal_flash_d;
      ball_reset_q <= ball_reset_d;
      beep_q       <= beep_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    saved_d        = saved_q;
    cnt_d          = cnt_q;
    score_one_d    = score_one_q;
    score_two_d    = score_two_q;
    winner_d       = winner_q;
    serve_dir_d    = serve_dir_q;
    ball_reset_evt = 1'b0;
    beep_evt       = 1'b0;

    case (state_q)
      StIdle, StOver: begin
        if (bus.start) begin
          score_one_d    = 4'd0;
          score_two_d    = 4'd0;
          winner_d       = 2'd0;
          serve_dir_d    = 1'b0;
          ball_reset_evt = 1'b1;
          cnt_d          = ServeDelay;
          state_d        = StServe;
        end
      end

      StServe: begin
        if (bus.pause_req) begin
          saved_d = StServe;
          state_d = StPaused;
        end else if (bus.tick) begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = StPlay;
          end
        end
      end

      StPlay: begin
        if (bus.pause_req) begin
          saved_d = StPlay;
          state_d = StPaused;
        end else if (bus.goal_one && bus.goal_two) begin
          // Simultaneous goals are a void rally: freeze, but nobody scores.
          cnt_d   = GoalHold;
          state_d = StGoal;
        end else if (bus.goal_one) begin
          if (score_one_q < WinScore) begin
            score_one_d = score_one_q + 4'd1;
          end
          serve_dir_d = 1'b1;
          beep_evt    = 1'b1;
          if (score_one_d == WinScore) begin
            winner_d = 2'd1;
            state_d  = StOver;
          end else begin
            cnt_d   = GoalHold;
            state_d = StGoal;
          end
        end else if (bus.goal_two) begin
          if (score_two_q < WinScore) begin
            score_two_d = score_two_q + 4'd1;
          end
          serve_dir_d = 1'b0;
          beep_evt    = 1'b1;
          if (score_two_d == WinScore) begin
            winner_d = 2'd2;
            state_d  = StOver;
          end else begin
            cnt_d   = GoalHold;
            state_d = StGoal;
          end
        end
      end

      StGoal: begin
        if (bus.tick) begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            ball_reset_evt = 1'b1;
            cnt_d          = ServeDelay;
            state_d        = StServe;
          end
        end
      end

      StPaused: begin
        // Resume wins over quit when both arrive together.
        if (bus.pause_req) begin
          state_d = saved_q;
        end else if (bus.start) begin
          score_one_d = 4'd0;
          score_two_d = 4'd0;
          winner_d    = 2'd0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    play_en_d    = (state_d == StPlay);
    goal_flash_d = (state_d == StGoal);
    ball_reset_d = ball_reset_evt;
    beep_d       = beep_evt;
  end

  assign bus.state      = state_q;
  assign bus.play_en    = play_en_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.serve_dir  = serve_dir_q;
  assign bus.score_one  = score_one_q;
  assign bus.score_two  = score_two_q;
  assign bus.winner     = winner_q;
  assign bus.goal_flash = goal_flash_q;
  assign bus.beep_req   = beep_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios plus randomized events
// compared cycle by cycle against a rule-level match model.
module tb_match_controller;

  localparam int unsigned WS = 2;
  localparam int unsigned SD = 6;
  localparam int unsigned GH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  match_controller_if bus ();

  match_controller #(
    .WIN_SCORE  (WS),
    .SERVE_DELAY(SD),
    .GOAL_HOLD  (GH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Match model: state numbers are the externally visible codes 0..5.
  int m_state, m_saved, m_cnt, m_s1, m_s2, m_win, m_dir, m_br, m_beep;

  task automatic model_reset();
    m_state = 0; m_saved = 1; m_cnt = 0; m_s1 = 0; m_s2 = 0;
    m_win = 0; m_dir = 0; m_br = 0; m_beep = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit p, input bit g1, input bit g2);
    m_br = 0;
    m_beep = 0;
    if (m_state == 0 || m_state == 5) begin
      if (s) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_br = 1;
        m_cnt = SD; m_state = 1;
      end
    end else if (m_state == 1 || m_state == 3) begin
      if (m_state == 1 && p) begin
        m_saved = 1; m_state = 4;
      end else if (t) begin
        if (m_cnt > 0) m_cnt--;
        else if (m_state == 1) m_state = 2;
        else begin
          m_br = 1; m_cnt = SD; m_state = 1;
        end
      end
    end else if (m_state == 2) begin
      if (p) begin
        m_saved = 2; m_state = 4;
      end else if (g1 && g2) begin
        m_cnt = GH; m_state = 3;
      end else if (g1 || g2) begin
        if (g1) begin
          m_s1 = (m_s1 < WS) ? m_s1 + 1 : m_s1;
          m_dir = 1;
        end else begin
          m_s2 = (m_s2 < WS) ? m_s2 + 1 : m_s2;
          m_dir = 0;
        end
        m_beep = 1;
        if ((g1 ? m_s1 : m_s2) == WS) begin
          m_win = g1 ? 1 : 2; m_state = 5;
        end else begin
          m_cnt = GH; m_state = 3;
        end
      end
    end else if (m_state == 4) begin
      if (p) m_state = m_saved;
      else if (s) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_state = 0;
      end
    end
  endtask

  // Drive one clock worth of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input bit t, input bit s, input bit p, input bit g1, input bit g2);
    bus.tick = t; bus.start = s; bus.pause_req = p; bus.goal_one = g1; bus.goal_two = g2;
    model_step(t, s, p, g1, g2);
    @(posedge clk);
    #1;
    bus.tick = 0; bus.start = 0; bus.pause_req = 0; bus.goal_one = 0; bus.goal_two = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.state !== 3'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", bus.state);
    end
    checks++;
    if ({bus.score_one, bus.score_two, bus.winner} !== 10'd0) begin
      failures++; $display("FAIL reset_scores got=%0d/%0d/%0d exp=0/0/0",
                           bus.score_one, bus.score_two, bus.winner);
    end
    checks++;
    if ({bus.play_en, bus.ball_reset, bus.goal_flash, bus.beep_req, bus.serve_dir} !== 5'd0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000",
                           {bus.play_en, bus.ball_reset, bus.goal_flash, bus.beep_req, bus.serve_dir});
    end
    // Everything but start is ignored in IDLE.
    cycle(1, 0, 1, 1, 1);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (bus.state !== 3'd0 || bus.score_two !== 4'd0 || bus.beep_req !== 1'b0) begin
      failures++; $display("FAIL idle_ignore got state=%0d s2=%0d beep=%b exp state=0 s2=0 beep=0",
                           bus.state, bus.score_two, bus.beep_req);
    end
  endtask

  task automatic test_serve();
    cycle(0, 1, 0, 0, 0);
    checks++;
    if (bus.state !== 3'd1 || bus.ball_reset !== 1'b1) begin
      failures++; $display("FAIL serve_entry got state=%0d ball_reset=%b exp state=1 ball_reset=1",
                           bus.state, bus.ball_reset);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.ball_reset !== 1'b0) begin
      failures++; $display("FAIL ball_reset_pulse got=%b exp=0", bus.ball_reset);
    end
    ticks(SD);
    checks++;
    if (bus.state !== 3'd1 || bus.play_en !== 1'b0) begin
      failures++; $display("FAIL serve_hold got state=%0d play_en=%b exp state=1 play_en=0",
                           bus.state, bus.play_en);
    end
    ticks(1);
    checks++;
    if (bus.state !== 3'd2 || bus.play_en !== 1'b1) begin
      failures++; $display("FAIL serve_release got state=%0d play_en=%b exp state=2 play_en=1",
                           bus.state, bus.play_en);
    end
  endtask

  task automatic test_match();
    int beeps;
    beeps = 0;
    cycle(0, 0, 0, 1, 0);
    beeps += int'(bus.beep_req);
    checks++;
    if (bus.state !== 3'd3 || bus.score_one !== 4'd1 || bus.serve_dir !== 1'b1 ||
        bus.goal_flash !== 1'b1) begin
      failures++; $display("FAIL goal_one got state=%0d s1=%0d dir=%b flash=%b exp 3/1/1/1",
                           bus.state, bus.score_one, bus.serve_dir, bus.goal_flash);
    end
    ticks(GH);
    beeps += int'(bus.beep_req);
    checks++;
    if (bus.state !== 3'd3) begin
      failures++; $display("FAIL goal_hold got state=%0d exp=3", bus.state);
    end
    ticks(1);
    checks++;
    if (bus.state !== 3'd1 || bus.ball_reset !== 1'b1 || bus.goal_flash !== 1'b0) begin
      failures++; $display("FAIL goal_exit got state=%0d ball_reset=%b flash=%b exp 1/1/0",
                           bus.state, bus.ball_reset, bus.goal_flash);
    end
    ticks(SD + 1);
    cycle(0, 0, 0, 1, 0);
    beeps += int'(bus.beep_req);
    checks++;
    if (bus.state !== 3'd5 || bus.score_one !== 4'd2 || bus.winner !== 2'd1 ||
        bus.play_en !== 1'b0) begin
      failures++; $display("FAIL match_win got state=%0d s1=%0d winner=%0d play_en=%b exp 5/2/1/0",
                           bus.state, bus.score_one, bus.winner, bus.play_en);
    end
    checks++;
    if (beeps != 2) begin
      failures++; $display("FAIL beep_count got=%0d exp=2", beeps);
    end
    cycle(1, 0, 1, 0, 1);
    checks++;
    if (bus.state !== 3'd5 || bus.score_two !== 4'd0 || bus.winner !== 2'd1) begin
      failures++; $display("FAIL over_hold got state=%0d s2=%0d winner=%0d exp 5/0/1",
                           bus.state, bus.score_two, bus.winner);
    end
  endtask

  task automatic test_simultaneous();
    cycle(0, 1, 0, 0, 0);
    checks++;
    if (bus.state !== 3'd1 || bus.score_one !== 4'd0 || bus.winner !== 2'd0) begin
      failures++; $display("FAIL restart got state=%0d s1=%0d winner=%0d exp 1/0/0",
                           bus.state, bus.score_one, bus.winner);
    end
    ticks(SD + 1);
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (bus.state !== 3'd3 || {bus.score_one, bus.score_two} !== 8'd0 || bus.beep_req !== 1'b0 ||
        bus.goal_flash !== 1'b1 || bus.serve_dir !== 1'b0) begin
      failures++; $display("FAIL both_goals got state=%0d s=%0d/%0d beep=%b flash=%b dir=%b",
                           bus.state, bus.score_one, bus.score_two, bus.beep_req,
                           bus.goal_flash, bus.serve_dir);
    end
    ticks(GH);
    checks++;
    if (bus.state !== 3'd3) begin
      failures++; $display("FAIL both_hold got state=%0d exp=3", bus.state);
    end
    ticks(1);
    checks++;
    if (bus.state !== 3'd1) begin
      failures++; $display("FAIL both_exit got state=%0d exp=1", bus.state);
    end
  endtask

  task automatic test_pause();
    do_reset();
    cycle(0, 1, 0, 0, 0);
    ticks(1);
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (bus.state !== 3'd4 || bus.play_en !== 1'b0) begin
      failures++; $display("FAIL pause_enter got state=%0d play_en=%b exp 4/0",
                           bus.state, bus.play_en);
    end
    ticks(10);
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (bus.state !== 3'd1) begin
      failures++; $display("FAIL pause_resume got state=%0d exp=1", bus.state);
    end
    ticks(SD - 1);
    checks++;
    if (bus.state !== 3'd1) begin
      failures++; $display("FAIL pause_cnt_hold got state=%0d exp=1", bus.state);
    end
    ticks(1);
    checks++;
    if (bus.state !== 3'd2) begin
      failures++; $display("FAIL pause_cnt_release got state=%0d exp=2", bus.state);
    end
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    checks++;
    if (bus.state !== 3'd2 || bus.play_en !== 1'b1) begin
      failures++; $display("FAIL pause_priority got state=%0d play_en=%b exp 2/1",
                           bus.state, bus.play_en);
    end
    cycle(0, 0, 0, 0, 1);
    ticks(GH + 1);
    ticks(SD + 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    checks++;
    if (bus.state !== 3'd0 || bus.score_two !== 4'd0 || bus.winner !== 2'd0) begin
      failures++; $display("FAIL pause_quit got state=%0d s2=%0d winner=%0d exp 0/0/0",
                           bus.state, bus.score_two, bus.winner);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(0, 1, 0, 0, 0);
    ticks(SD + 1);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (bus.state !== 3'd3 || bus.score_two !== 4'd1) begin
      failures++; $display("FAIL pre_reset got state=%0d s2=%0d exp 3/1", bus.state, bus.score_two);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.score_two !== 4'd0 || bus.goal_flash !== 1'b0) begin
      failures++; $display("FAIL async_reset got state=%0d s2=%0d flash=%b exp 0/0/0",
                           bus.state, bus.score_two, bus.goal_flash);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 1);
      checks++;
      if (bus.ball_reset !== 1'b0 || bus.beep_req !== 1'b0 || bus.state !== 3'd0) begin
        failures++; $display("FAIL post_reset cyc=%0d ball_reset=%b beep=%b state=%0d exp 0/0/0",
                             i, bus.ball_reset, bus.beep_req, bus.state);
      end
    end
  endtask

  task automatic test_random();
    logic [18:0] got, exp;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle($urandom_range(0, 1) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      got = {bus.state, bus.play_en, bus.ball_reset, bus.serve_dir, bus.score_one,
             bus.score_two, bus.winner, bus.goal_flash, bus.beep_req};
      exp = {3'(m_state), m_state == 2, 1'(m_br), 1'(m_dir), 4'(m_s1), 4'(m_s2),
             2'(m_win), m_state == 3, 1'(m_beep)};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.tick = 0; bus.start = 0; bus.pause_req = 0; bus.goal_one = 0; bus.goal_two = 0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_serve();
    test_match();
    test_simultaneous();
    test_pause();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
